// File: rtl/register_file_scoreboard_if.sv
// Decode/writeback bus of register_file_scoreboard: write port, two read ports,
// issue port and scoreboard status. Signal names match the legacy register file.
interface register_file_scoreboard_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 3
);
   logic              RegWrite;
   logic [ADDR_W-1:0] write_register;
   logic [DATA_W-1:0] write_data;
   logic [ADDR_W-1:0] read_register_1;
   logic [DATA_W-1:0] read_data_1;
   logic [ADDR_W-1:0] read_register_2;
   logic [DATA_W-1:0] read_data_2;
   logic              issue_valid;
   logic [ADDR_W-1:0] issue_register;
   logic              pending_1;
   logic              pending_2;
   logic [ADDR_W:0]   pending_count;

   modport master (
      output RegWrite, write_register, write_data,
      output read_register_1, read_register_2,
      output issue_valid, issue_register,
      input  read_data_1, read_data_2, pending_1, pending_2, pending_count
   );

   modport slave (
      input  RegWrite, write_register, write_data,
      input  read_register_1, read_register_2,
      input  issue_valid, issue_register,
      output read_data_1, read_data_2, pending_1, pending_2, pending_count
   );
endinterface

// File: rtl/register_file_scoreboard.sv
// Register file with r0 hardwired to zero and a per-register pending scoreboard.
// Optional same-cycle write-to-read bypass: define RF_BYPASS_EN.
module register_file_scoreboard #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 3
) (
   input logic                     clk,
   input logic                     rst_n,
   register_file_scoreboard_if.slave rf
);
   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  r_pend;
   logic [ADDR_W:0]   r_count;

   logic [DEPTH-1:0]  w_wr_mask;
   logic [DEPTH-1:0]  w_is_mask;
   logic [DEPTH-1:0]  w_pend_next;
   logic [ADDR_W:0]   w_count_next;
   logic              w_wr_en;

   assign w_wr_en = rf.RegWrite && (rf.write_register != '0);

   // Issue is applied after the clear so a same-edge issue supersedes the write.
   always_comb begin
      w_wr_mask    = '0;
      w_is_mask    = '0;
      if (rf.RegWrite)
         w_wr_mask = DEPTH'(1) << rf.write_register;
      if (rf.issue_valid)
         w_is_mask = DEPTH'(1) << rf.issue_register;
      w_pend_next    = (r_pend & ~w_wr_mask) | w_is_mask;
      w_pend_next[0] = 1'b0;
      w_count_next   = (ADDR_W+1)'($countones(w_pend_next));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem <= '{default: '0};
      end else if (w_wr_en) begin
         r_mem[rf.write_register] <= rf.write_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend  <= '0;
         r_count <= '0;
      end else begin
         r_pend  <= w_pend_next;
         r_count <= w_count_next;
      end
   end

`ifdef RF_BYPASS_EN
   logic w_byp_1;
   logic w_byp_2;

   assign w_byp_1 = rst_n && w_wr_en && (rf.write_register == rf.read_register_1);
   assign w_byp_2 = rst_n && w_wr_en && (rf.write_register == rf.read_register_2);

   always_comb begin
      rf.read_data_1 = r_mem[rf.read_register_1];
      rf.read_data_2 = r_mem[rf.read_register_2];
      rf.pending_1   = r_pend[rf.read_register_1];
      rf.pending_2   = r_pend[rf.read_register_2];
      if (w_byp_1) begin
         rf.read_data_1 = rf.write_data;
         rf.pending_1   = rf.issue_valid && (rf.issue_register == rf.read_register_1);
      end
      if (w_byp_2) begin
         rf.read_data_2 = rf.write_data;
         rf.pending_2   = rf.issue_valid && (rf.issue_register == rf.read_register_2);
      end
   end
`else
   always_comb begin
      rf.read_data_1 = r_mem[rf.read_register_1];
      rf.read_data_2 = r_mem[rf.read_register_2];
      rf.pending_1   = r_pend[rf.read_register_1];
      rf.pending_2   = r_pend[rf.read_register_2];
   end
`endif

   assign rf.pending_count = r_count;
endmodule

// File: tb/tb_register_file_scoreboard.sv
// Randomized and directed bench for register_file_scoreboard against a
// behavioural model (array of values plus a set of pending registers).
module tb_register_file_scoreboard;
   localparam int unsigned DW = 16;
   localparam int unsigned AW = 3;

   logic clk;
   logic rst_n;

   register_file_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   register_file_scoreboard #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rf    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [DW-1:0] m_mem [8];
   bit            m_pend [int];

`ifdef RF_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) m_mem[i] = '0;
      m_pend.delete();
   endfunction

   function automatic bit bypassed(input logic [AW-1:0] a);
      return BYPASS && rst_n && bus.RegWrite && bus.write_register != 0 && bus.write_register == a;
   endfunction

   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
      if (!rst_n) return '0;
      if (bypassed(a)) return bus.write_data;
      return (a == 0) ? '0 : m_mem[a];
   endfunction

   function automatic logic exp_pend(input logic [AW-1:0] a);
      if (!rst_n) return 1'b0;
      if (bypassed(a)) return bus.issue_valid && bus.issue_register == a;
      return m_pend.exists(int'(a));
   endfunction

   task automatic check_all(input string ph);
      chk({ph, "_rd1"},   32'(bus.read_data_1),   32'(exp_rd(bus.read_register_1)));
      chk({ph, "_rd2"},   32'(bus.read_data_2),   32'(exp_rd(bus.read_register_2)));
      chk({ph, "_pnd1"},  32'(bus.pending_1),     32'(exp_pend(bus.read_register_1)));
      chk({ph, "_pnd2"},  32'(bus.pending_2),     32'(exp_pend(bus.read_register_2)));
      chk({ph, "_count"}, 32'(bus.pending_count), (rst_n ? m_pend.num() : 0));
   endtask

   // Drives one cycle's worth of inputs, checks before and after the edge.
   task automatic cycle(input bit we, input int wa, input int wd, input bit iv, input int ia,
                        input int r1, input int r2);
      bus.RegWrite        = we;
      bus.write_register  = AW'(wa);
      bus.write_data      = DW'(wd);
      bus.issue_valid     = iv;
      bus.issue_register  = AW'(ia);
      bus.read_register_1 = AW'(r1);
      bus.read_register_2 = AW'(r2);
      #2;
      check_all("pre");
      @(posedge clk);
      if (rst_n) begin
         if (we && wa != 0) begin
            m_mem[wa] = DW'(wd);
            m_pend.delete(wa);
         end
         if (iv && ia != 0) m_pend[ia] = 1'b1;
      end
      #1;
      bus.RegWrite    = 1'b0;
      bus.issue_valid = 1'b0;
      #1;
      check_all("post");
   endtask

   task automatic async_reset_pulse();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_count", 32'(bus.pending_count), 0);
      chk("async_rd1", 32'(bus.read_data_1), 0);
      rst_n = 1'b1;
   endtask

   initial begin
      int wa, ia, r1, r2;
      rst_n = 1'b0;
      bus.RegWrite = 1'b0; bus.write_register = '0; bus.write_data = '0;
      bus.issue_valid = 1'b0; bus.issue_register = '0;
      bus.read_register_1 = '0; bus.read_register_2 = '0;
      model_reset();

      // Reset holds off writes, issues and bypass
      cycle(1, 4, 20, 1, 4, 4, 4);
      cycle(1, 4, 20, 1, 4, 4, 0);
      chk("rst_count", 32'(bus.pending_count), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_r4", 32'(bus.read_data_1), 0);

      // Write/read latency
      cycle(1, 4, 20, 0, 0, 4, 0);
      chk("r4_val", 32'(bus.read_data_1), 20);

      // Register 0 never stored nor bypassed
      cycle(1, 0, 16'hBEEF, 0, 0, 0, 0);
      chk("r0_rd1", 32'(bus.read_data_1), 0);
      chk("r0_rd2", 32'(bus.read_data_2), 0);

      // Scoreboard sequence
      cycle(0, 0, 0, 1, 3, 3, 5);
      chk("sb_cnt1", 32'(bus.pending_count), 1);
      cycle(0, 0, 0, 1, 5, 3, 5);
      chk("sb_cnt2", 32'(bus.pending_count), 2);
      cycle(1, 3, 7, 0, 0, 3, 5);
      chk("sb_cnt3", 32'(bus.pending_count), 1);
      chk("sb_p3", 32'(bus.pending_1), 0);
      chk("sb_r3", 32'(bus.read_data_1), 7);
      cycle(1, 5, 9, 0, 0, 3, 5);
      chk("sb_cnt4", 32'(bus.pending_count), 0);

      // Same-edge issue and write
      cycle(0, 0, 0, 1, 6, 6, 6);
      cycle(1, 6, 42, 1, 6, 6, 6);
      chk("sim_r6", 32'(bus.read_data_1), 42);
      chk("sim_p6", 32'(bus.pending_1), 1);
      chk("sim_cnt", 32'(bus.pending_count), 1);

      // Async reset mid-operation
      cycle(0, 0, 0, 1, 2, 2, 7);
      cycle(0, 0, 0, 1, 7, 2, 7);
      async_reset_pulse();
      cycle(1, 2, 5, 0, 0, 2, 7);
      chk("post_rst_cnt", 32'(bus.pending_count), 0);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         wa = $urandom_range(0, 7);
         ia = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 7);
         r1 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 7);
         r2 = ($urandom_range(0, 2) == 0) ? ia : $urandom_range(0, 7);
         cycle($urandom_range(0, 1), wa, $urandom_range(0, 16'hFFFF),
               $urandom_range(0, 1), ia, r1, r2);
         if ($urandom_range(0, 49) == 0) async_reset_pulse();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
